duty_table_writer: RTL and testbench

//  Write-side engine for the 64 KiB x 8-bit duty table (IDX 16b -> VALUE 8b, read latency 2 CLK).

---
 rtl/duty_table_pkg.sv | 37 +++
 rtl/duty_table_fill_gen.sv | 103 ++++++++++
 rtl/duty_table_writer.sv | 133 +++++++++++++
 tb/tb_duty_table_writer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/duty_table_pkg.sv
// ---------------------------------------------------------------------------
// duty_table_pkg
// Shared constants and types for the duty-table write engine.
//   - Geometry of the 64 KiB x 8-bit duty table. It is stored as 32768 words,
//     and each word holds two entries.
//   - Host bus region codes and the control address of the page register.
//   - Fill engine state type and the ramp data helper.
// The fill engine is only built when DUTY_TABLE_FILL_EN is defined.
// ---------------------------------------------------------------------------
package duty_table_pkg;

  localparam int BUS_ADDR_W        = 14;
  localparam int PAGE_W            = 1;
  localparam int DUTY_TABLE_WORDS  = 32768;
  localparam int DUTY_TABLE_ADDR_W = 15;

  localparam logic [1:0]            SEL_TABLE = 2'b11;
  localparam logic [1:0]            SEL_CTL   = 2'b00;
  localparam logic [BUS_ADDR_W-1:0] PAGE_REG  = 14'h010;

  localparam logic [DUTY_TABLE_ADDR_W-1:0] LAST_WORD = 15'(DUTY_TABLE_WORDS - 1);
  localparam logic [7:0]                   DROP_MAX  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    DONE_ST = 2'd2
  } fill_state_t;

  // Ramp data for word w. Entry i receives the value i[15:8].
  // Both entries of word w have indices 2w and 2w+1, and the two indices share
  // the same upper byte w[14:7]. The word is therefore that byte written twice.
  function automatic logic [15:0] rampWord(input logic [DUTY_TABLE_ADDR_W-1:0] w);
    return {w[14:7], w[14:7]};
  endfunction

endpackage

// File: rtl/duty_table_fill_gen.sv
// ---------------------------------------------------------------------------
// duty_table_fill_gen
// Hardware fill engine. It overwrites the whole duty table, one word per clock.
// The module is only compiled when DUTY_TABLE_FILL_EN is defined.
// Ports:
//   clk_i, rst_ni     clock and asynchronous active-low reset
//   fill_start_i      start pulse. It is ignored unless the FSM is idle.
//   fill_mode_i       0 = constant fill_value_i, 1 = ramp. Latched at start.
//   fill_value_i      constant used in mode 0. Latched at start.
//   busy_o            high while words are being generated
//   done_o            one-cycle pulse after the last word was presented
//   fill_we_o         registered write request toward the table port
//   fill_addr_o       registered word address
//   fill_din_o        registered word data
// ---------------------------------------------------------------------------
`ifdef DUTY_TABLE_FILL_EN
module duty_table_fill_gen
  import duty_table_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         fill_start_i,
  input  logic                         fill_mode_i,
  input  logic [7:0]                   fill_value_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         fill_we_o,
  output logic [DUTY_TABLE_ADDR_W-1:0] fill_addr_o,
  output logic [15:0]                  fill_din_o
);

  fill_state_t                  state_q;
  logic [DUTY_TABLE_ADDR_W-1:0] word_q;
  logic                         mode_q;
  logic [7:0]                   value_q;
  logic                         busy_q;
  logic                         done_q;
  logic                         we_q;
  logic [DUTY_TABLE_ADDR_W-1:0] addr_q;
  logic [15:0]                  din_q;

  // The write request is registered one cycle behind the FSM. busy_q therefore
  // leads fill_we_o by one clock. A host write seen in the cycle that starts a
  // fill still owns the next output slot, and every host write sampled while
  // busy is refused. Because of this the host path and the fill path can never
  // drive the table port in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      word_q  <= '0;
      mode_q  <= 1'b0;
      value_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fill_start_i) begin
            state_q <= FILL;
            word_q  <= '0;
            mode_q  <= fill_mode_i;
            value_q <= fill_value_i;
            busy_q  <= 1'b1;
          end
        end
        FILL: begin
          we_q   <= 1'b1;
          addr_q <= word_q;
          din_q  <= mode_q ? rampWord(word_q) : {value_q, value_q};
          if (word_q == LAST_WORD) begin
            state_q <= DONE_ST;
            busy_q  <= 1'b0;
          end else begin
            word_q <= word_q + 1'b1;
          end
        end
        DONE_ST: begin
          // The last word is on the port during this state, so the pulse
          // lands in the cycle after that word is written.
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fill_we_o   = we_q;
  assign fill_addr_o = addr_q;
  assign fill_din_o  = din_q;

endmodule
`endif

// File: rtl/duty_table_writer.sv
// ---------------------------------------------------------------------------
// duty_table_writer
// Write-side engine for the duty table BRAM. It performs three jobs:
//   - It turns host bus writes into writes on the 16-bit table port.
//   - It holds the page register that selects the upper half of the table.
//   - It optionally hosts the fill engine. This requires DUTY_TABLE_FILL_EN.
//     Without that macro the fill inputs are ignored and
//     busy_o, done_o and drop_cnt_o stay at zero.
// Ports:
//   clk_i, rst_ni     clock and asynchronous active-low reset
//   bus_en_i          host access strobe
//   bus_we_i          host write enable
//   bus_sel_i         host region select
//   bus_addr_i        host word address
//   bus_data_i        write data. [7:0] is the even entry, [15:8] the odd entry.
//   fill_start_i      fill engine start pulse
//   fill_mode_i       fill mode (0 constant, 1 ramp)
//   fill_value_i      constant for mode 0
//   tbl_we_o          table write enable
//   tbl_addr_o        table word address {page, bus address}
//   tbl_din_o         table word data
//   page_o            current page register
//   busy_o            fill engine active
//   done_o            fill completion pulse
//   drop_cnt_o        saturating count of host table writes refused while busy
// ---------------------------------------------------------------------------
module duty_table_writer
  import duty_table_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         bus_en_i,
  input  logic                         bus_we_i,
  input  logic [1:0]                   bus_sel_i,
  input  logic [BUS_ADDR_W-1:0]        bus_addr_i,
  input  logic [15:0]                  bus_data_i,
  input  logic                         fill_start_i,
  input  logic                         fill_mode_i,
  input  logic [7:0]                   fill_value_i,
  output logic                         tbl_we_o,
  output logic [DUTY_TABLE_ADDR_W-1:0] tbl_addr_o,
  output logic [15:0]                  tbl_din_o,
  output logic [PAGE_W-1:0]            page_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [7:0]                   drop_cnt_o
);

  logic                         hostTblWr;
  logic                         pageWr;
  logic                         fillBusy;
  logic                         fillDone;
  logic                         fillWe;
  logic [DUTY_TABLE_ADDR_W-1:0] fillAddr;
  logic [15:0]                  fillDin;

  logic                         hostWe_q,   hostWe_d;
  logic [DUTY_TABLE_ADDR_W-1:0] hostAddr_q, hostAddr_d;
  logic [15:0]                  hostDin_q,  hostDin_d;
  logic [PAGE_W-1:0]            page_q,     page_d;
  logic [7:0]                   dropCnt_q,  dropCnt_d;

  assign hostTblWr = bus_en_i & bus_we_i & (bus_sel_i == SEL_TABLE);
  assign pageWr    = bus_en_i & bus_we_i & (bus_sel_i == SEL_CTL) & (bus_addr_i == PAGE_REG);

`ifdef DUTY_TABLE_FILL_EN
  duty_table_fill_gen u_fill_gen (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .fill_start_i (fill_start_i),
    .fill_mode_i  (fill_mode_i),
    .fill_value_i (fill_value_i),
    .busy_o       (fillBusy),
    .done_o       (fillDone),
    .fill_we_o    (fillWe),
    .fill_addr_o  (fillAddr),
    .fill_din_o   (fillDin)
  );
`else
  logic unusedFillInputs;
  assign unusedFillInputs = ^{fill_start_i, fill_mode_i, fill_value_i};
  assign fillBusy = 1'b0;
  assign fillDone = 1'b0;
  assign fillWe   = 1'b0;
  assign fillAddr = '0;
  assign fillDin  = '0;
`endif

  // Next-state logic for the host path, the page register and the drop counter.
  // A table write in the same cycle as a page write still uses the old page,
  // because page_q only changes at the next edge.
  always_comb begin
    hostWe_d   = hostTblWr & ~fillBusy;
    hostAddr_d = hostAddr_q;
    hostDin_d  = hostDin_q;
    if (hostWe_d) begin
      hostAddr_d = {page_q, bus_addr_i};
      hostDin_d  = bus_data_i;
    end
    page_d = pageWr ? bus_data_i[PAGE_W-1:0] : page_q;
    dropCnt_d = dropCnt_q;
    if (hostTblWr && fillBusy && (dropCnt_q != DROP_MAX)) begin
      dropCnt_d = dropCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hostWe_q   <= 1'b0;
      hostAddr_q <= '0;
      hostDin_q  <= '0;
      page_q     <= '0;
      dropCnt_q  <= '0;
    end else begin
      hostWe_q   <= hostWe_d;
      hostAddr_q <= hostAddr_d;
      hostDin_q  <= hostDin_d;
      page_q     <= page_d;
      dropCnt_q  <= dropCnt_d;
    end
  end

  // Both sources are registered, so this mux only steers the port.
  // The fill engine's one-cycle lag means the two sources never both request.
  assign tbl_we_o   = fillWe | hostWe_q;
  assign tbl_addr_o = fillWe ? fillAddr : hostAddr_q;
  assign tbl_din_o  = fillWe ? fillDin  : hostDin_q;
  assign page_o     = page_q;
  assign busy_o     = fillBusy;
  assign done_o     = fillDone;
  assign drop_cnt_o = dropCnt_q;

endmodule

// File: tb/tb_duty_table_writer.sv
// ---------------------------------------------------------------------------
// tb_duty_table_writer
// Self-checking bench for duty_table_writer. Every expected table write is
// queued when it is driven. The queue is popped whenever tbl_we is observed.
// A shadow byte array plays the role of the BRAM, so table contents can be
// read back by entry index. Fill tests run only with DUTY_TABLE_FILL_EN.
// ---------------------------------------------------------------------------
module tb_duty_table_writer;
  import duty_table_pkg::*;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        busEn = 1'b0;
  logic        busWe = 1'b0;
  logic [1:0]  busSel = 2'b00;
  logic [13:0] busAddr = '0;
  logic [15:0] busData = '0;
  logic        fillStart = 1'b0;
  logic        fillMode = 1'b0;
  logic [7:0]  fillValue = '0;
  logic        tblWe;
  logic [14:0] tblAddr;
  logic [15:0] tblDin;
  logic [0:0]  page;
  logic        busy;
  logic        done;
  logic [7:0]  dropCnt;

  int totalChecks = 0;
  int badChecks = 0;
  int weSeen = 0;
  int busyCycles = 0;
  int doneCount = 0;
  int sweepErrs;
  int waitCnt;
  logic [0:0]  modelPage = 1'b0;
  logic [30:0] expWord;
  logic [30:0] sbQueue[$];
  logic [7:0]  shadowMem [0:65535];
  logic [15:0] evenIdx;
  logic [15:0] oddIdx;
  logic [15:0] rnd;

  always #5 clk = ~clk;

  duty_table_writer dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .bus_en_i     (busEn),
    .bus_we_i     (busWe),
    .bus_sel_i    (busSel),
    .bus_addr_i   (busAddr),
    .bus_data_i   (busData),
    .fill_start_i (fillStart),
    .fill_mode_i  (fillMode),
    .fill_value_i (fillValue),
    .tbl_we_o     (tblWe),
    .tbl_addr_o   (tblAddr),
    .tbl_din_o    (tblDin),
    .page_o       (page),
    .busy_o       (busy),
    .done_o       (done),
    .drop_cnt_o   (dropCnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds a bus access for one clock, then releases the strobe.
  task automatic applyStimulus(input logic en, input logic we, input logic [1:0] sel,
                               input logic [13:0] addr, input logic [15:0] data);
    busEn = en;
    busWe = we;
    busSel = sel;
    busAddr = addr;
    busData = data;
    tick();
    busEn = 1'b0;
    busWe = 1'b0;
  endtask

  task automatic hostWrite(input logic [13:0] addr, input logic [15:0] data);
    sbQueue.push_back({modelPage, addr, data});
    applyStimulus(1'b1, 1'b1, SEL_TABLE, addr, data);
  endtask

  task automatic pushFill(input logic mode, input logic [7:0] value);
    for (int w = 0; w < 32768; w++) begin
      evenIdx = 16'(2 * w);
      oddIdx  = 16'(2 * w + 1);
      if (mode) sbQueue.push_back({15'(w), oddIdx[15:8], evenIdx[15:8]});
      else      sbQueue.push_back({15'(w), value, value});
    end
  endtask

  task automatic waitDone(input string tag);
    waitCnt = 0;
    while (doneCount == 0 && waitCnt < 40000) begin
      tick();
      waitCnt++;
    end
    checkOutput(tag, 32'(doneCount == 0), 32'd0);
  endtask

  // Monitor: models the BRAM and checks every table write against the queue.
  always @(negedge clk) begin
    if (rstN) begin
      if (busy) busyCycles++;
      if (done) doneCount++;
      if (tblWe) begin
        weSeen++;
        shadowMem[{tblAddr, 1'b0}] = tblDin[7:0];
        shadowMem[{tblAddr, 1'b1}] = tblDin[15:8];
        if (sbQueue.size() == 0) begin
          checkOutput("unexpected_we", {1'b0, tblAddr, tblDin}, 32'hFFFF_FFFF);
        end else begin
          expWord = sbQueue.pop_front();
          checkOutput("tbl_write", {1'b0, tblAddr, tblDin}, {1'b0, expWord});
        end
      end
    end
  end

  initial begin
    #12;
    checkOutput("rst_we", 32'(tblWe), 32'd0);
    checkOutput("rst_addr", 32'(tblAddr), 32'd0);
    checkOutput("rst_din", 32'(tblDin), 32'd0);
    checkOutput("rst_page", 32'(page), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_drop", 32'(dropCnt), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    tick();

    // Basic host write
    hostWrite(14'h0005, 16'hA55A);
    tick();
    checkOutput("sb_drain_basic", 32'(sbQueue.size()), 32'd0);

    // Page register, then a write at the top of page 1
    applyStimulus(1'b1, 1'b1, SEL_CTL, PAGE_REG, 16'h0001);
    modelPage = 1'b1;
    checkOutput("page_set", 32'(page), 32'd1);
    hostWrite(14'h3FFF, 16'h1234);
    tick();
    checkOutput("idx_fffe", 32'(shadowMem[16'hFFFE]), 32'h34);
    checkOutput("idx_ffff", 32'(shadowMem[16'hFFFF]), 32'h12);

    // Accesses that must not produce table writes or page changes
    applyStimulus(1'b1, 1'b0, SEL_TABLE, 14'h0123, 16'hDEAD);
    applyStimulus(1'b1, 1'b1, 2'b01, 14'h0123, 16'hDEAD);
    applyStimulus(1'b0, 1'b1, SEL_TABLE, 14'h0124, 16'hBEEF);
    applyStimulus(1'b1, 1'b1, SEL_CTL, 14'h0011, 16'h0000);
    applyStimulus(1'b1, 1'b0, SEL_CTL, PAGE_REG, 16'h0000);
    tick();
    checkOutput("page_kept", 32'(page), 32'd1);

    // Back-to-back writes across a page change
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        applyStimulus(1'b1, 1'b1, SEL_CTL, PAGE_REG, 16'hFFFE);
        modelPage = 1'b0;
      end
      rnd = 16'($urandom);
      hostWrite(14'($urandom), rnd);
    end
    tick();
    checkOutput("page_cleared", 32'(page), 32'd0);
    checkOutput("sb_drain_host", 32'(sbQueue.size()), 32'd0);

`ifdef DUTY_TABLE_FILL_EN
    // Constant fill started together with a host write. Then 300 writes are
    // refused while busy, and a second start is ignored mid-fill.
    busyCycles = 0;
    doneCount = 0;
    sbQueue.push_back({1'b0, 14'h0100, 16'hBEEF});
    pushFill(1'b0, 8'h7F);
    fillStart = 1'b1;
    fillMode = 1'b0;
    fillValue = 8'h7F;
    applyStimulus(1'b1, 1'b1, SEL_TABLE, 14'h0100, 16'hBEEF);
    fillStart = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        fillStart = 1'b1;
        fillMode = 1'b1;
        fillValue = 8'h00;
      end
      applyStimulus(1'b1, 1'b1, SEL_TABLE, 14'(i), 16'h0000);
      fillStart = 1'b0;
    end
    waitDone("fill0_timeout");
    tick(); tick(); tick();
    checkOutput("fill0_busy_cycles", 32'(busyCycles), 32'd32768);
    checkOutput("fill0_done_count", 32'(doneCount), 32'd1);
    checkOutput("drop_saturated", 32'(dropCnt), 32'd255);
    checkOutput("sb_drain_fill0", 32'(sbQueue.size()), 32'd0);
    sweepErrs = 0;
    for (int i = 0; i < 65536; i++) if (shadowMem[i] !== 8'h7F) sweepErrs++;
    checkOutput("fill0_sweep", 32'(sweepErrs), 32'd0);

    // Abort a fill with reset at word 1000
    pushFill(1'b0, 8'h55);
    weSeen = 0;
    fillStart = 1'b1;
    fillMode = 1'b0;
    fillValue = 8'h55;
    tick();
    fillStart = 1'b0;
    waitCnt = 0;
    while (weSeen < 1000 && waitCnt < 5000) begin
      tick();
      waitCnt++;
    end
    checkOutput("abort_reach_1000", 32'(weSeen < 1000), 32'd0);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_we", 32'(tblWe), 32'd0);
    checkOutput("abort_drop", 32'(dropCnt), 32'd0);
    sbQueue.delete();
    doneCount = 0;
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("abort_no_done", 32'(doneCount), 32'd0);

    // Fresh ramp fill after the abort
    busyCycles = 0;
    doneCount = 0;
    pushFill(1'b1, 8'h00);
    fillStart = 1'b1;
    fillMode = 1'b1;
    fillValue = 8'hAA;
    tick();
    fillStart = 1'b0;
    waitDone("fill1_timeout");
    tick(); tick(); tick();
    checkOutput("fill1_busy_cycles", 32'(busyCycles), 32'd32768);
    checkOutput("fill1_done_count", 32'(doneCount), 32'd1);
    checkOutput("sb_drain_fill1", 32'(sbQueue.size()), 32'd0);
    checkOutput("ramp_idx_01ff", 32'(shadowMem[16'h01FF]), 32'h01);
    checkOutput("ramp_idx_ffff", 32'(shadowMem[16'hFFFF]), 32'hFF);
    sweepErrs = 0;
    for (int i = 0; i < 65536; i++) begin
      evenIdx = 16'(i);
      if (shadowMem[i] !== evenIdx[15:8]) sweepErrs++;
    end
    checkOutput("fill1_sweep", 32'(sweepErrs), 32'd0);
`else
    // Without the fill engine, fill inputs do nothing and host writes still pass
    busyCycles = 0;
    doneCount = 0;
    sbQueue.push_back({1'b0, 14'h0100, 16'hBEEF});
    fillStart = 1'b1;
    fillValue = 8'h7F;
    applyStimulus(1'b1, 1'b1, SEL_TABLE, 14'h0100, 16'hBEEF);
    fillStart = 1'b0;
    for (int i = 0; i < 3; i++) hostWrite(14'(i + 7), 16'(i * 16'h1111));
    for (int i = 0; i < 10; i++) tick();
    checkOutput("nofill_busy", 32'(busyCycles), 32'd0);
    checkOutput("nofill_done", 32'(doneCount), 32'd0);
    checkOutput("nofill_drop", 32'(dropCnt), 32'd0);
    checkOutput("sb_drain_nofill", 32'(sbQueue.size()), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
